character_state_ctrl: RTL and testbench

- Per-character life/score/state tracker for the Mario game core.
- Consumes one-cycle collision events from the collision detector (side bits plus object type code) and runs a life-cycle FSM (ALIVE, DYING, INVULN, GAME_OVER).
- Keeps a saturating score and a life counter.
- Drives the sprite/renderer state code and HUD score/life values.

---
 rtl/character_pkg.sv | 13 +
 rtl/char_timer.sv | 16 +
 rtl/character_state_ctrl.sv | 129 ++++++++++++
 tb/tb_character_state_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/character_pkg.sv
// character_pkg: shared state encoding, collision side indices and object type codes.
package character_pkg;
  typedef enum logic [1:0] {ALIVE, DYING, INVULN, GAME_OVER} char_state_e;
  localparam int UP = 3;
  localparam int DOWN = 2;
  localparam int LEFT = 1;
  localparam int RIGHT = 0;
  localparam int COIN = 102;
  localparam int MONSTER = 302;
  function automatic int timer_w(int a, int b);
    return ($clog2((a > b) ? a : b) < 1) ? 1 : $clog2((a > b) ? a : b);
  endfunction
endpackage

// File: rtl/char_timer.sv
// char_timer: loadable down-counter that parks at zero and flags it.
module char_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? load_val : zero ? cnt : cnt - 1'b1;
endmodule

// File: rtl/character_state_ctrl.sv
// character_state_ctrl: life/score/state tracker for one character.
// Optional coin-driven extra life enabled by defining CHARACTER_EXTRA_LIFE_EN.
module character_state_ctrl
  import character_pkg::*;
#(
  parameter int TYPE_W = 11,
  parameter int SCORE_W = 11,
  parameter int LIFE_W = 4,
  parameter int INIT_LIFE = 3,
  parameter int COIN_TYPE = COIN,
  parameter int MONSTER_TYPE = MONSTER,
  parameter int COIN_POINTS = 1,
  parameter int STOMP_POINTS = 3,
`ifdef CHARACTER_EXTRA_LIFE_EN
  parameter int COINS_PER_LIFE = 100,
`endif
  parameter int DYING_CYCLES = 60,
  parameter int INVULN_CYCLES = 120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        collision,
  input  logic [TYPE_W-1:0] collision_type,
  input  logic              collision_valid,
  input  logic              restart,
  output logic [1:0]        state,
  output logic [SCORE_W-1:0] score,
  output logic [LIFE_W-1:0] life,
  output logic              die_pulse,
  output logic              stomp_pulse,
`ifdef CHARACTER_EXTRA_LIFE_EN
  output logic              oneup_pulse,
`endif
  output logic              coin_pulse
);
  localparam int TIMER_W = timer_w(DYING_CYCLES, INVULN_CYCLES);
  localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};
  char_state_e state_q, state_d;
  logic [SCORE_W-1:0] score_d;
  logic [LIFE_W-1:0] life_d;
  logic die_d, stomp_d, coin_d, t_load, t_zero, monster, live, hit, stomp, coin;
  logic [TIMER_W-1:0] t_val;
  logic [SCORE_W:0] sum;
  logic unused_sides;
  assign unused_sides = ^{collision[UP], collision[LEFT], collision[RIGHT]};
  assign monster = collision_valid && collision_type == TYPE_W'(MONSTER_TYPE);
  assign hit = monster && !collision[DOWN];
  assign stomp = monster && collision[DOWN];
  assign coin = collision_valid && collision_type == TYPE_W'(COIN_TYPE);
  assign live = state_q == ALIVE || state_q == INVULN;
  assign sum = {1'b0, score} + ((live && stomp) ? (SCORE_W+1)'(STOMP_POINTS) :
                                (live && coin) ? (SCORE_W+1)'(COIN_POINTS) : '0);
  assign state = state_q;
`ifdef CHARACTER_EXTRA_LIFE_EN
  localparam int CNT_W = $clog2(COINS_PER_LIFE + 1);
  logic [CNT_W-1:0] coins_q, coins_d;
  logic oneup_d;
`endif
  always_comb begin
    state_d = state_q;
    life_d = life;
    stomp_d = live && stomp;
    coin_d = live && coin;
    score_d = sum > SCORE_MAX ? SCORE_MAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
    die_d = 1'b0;
    t_load = 1'b0;
    t_val = '0;
    case (state_q)
      ALIVE: if (hit) begin
        state_d = DYING;
        life_d = life - 1'b1;
        die_d = 1'b1;
        t_load = 1'b1;
        t_val = TIMER_W'(DYING_CYCLES - 1);
      end
      DYING: if (t_zero) begin
        state_d = life == '0 ? GAME_OVER : INVULN;
        t_load = life != '0;
        t_val = TIMER_W'(INVULN_CYCLES - 1);
      end
      INVULN: if (t_zero) state_d = ALIVE;
      default: if (restart) begin
        state_d = ALIVE;
        score_d = '0;
        life_d = LIFE_W'(INIT_LIFE);
      end
    endcase
`ifdef CHARACTER_EXTRA_LIFE_EN
    // coins and monsters never coincide, so this cannot clash with a hit
    oneup_d = coin_d && coins_q == CNT_W'(COINS_PER_LIFE - 1);
    coins_d = (state_q == GAME_OVER && restart) || oneup_d ? '0 :
              coin_d ? coins_q + 1'b1 : coins_q;
    if (oneup_d && life != '1) life_d = life + 1'b1;
`endif
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= ALIVE;
      score <= '0;
      life <= LIFE_W'(INIT_LIFE);
      die_pulse <= 1'b0;
      stomp_pulse <= 1'b0;
      coin_pulse <= 1'b0;
    end else begin
      state_q <= state_d;
      score <= score_d;
      life <= life_d;
      die_pulse <= die_d;
      stomp_pulse <= stomp_d;
      coin_pulse <= coin_d;
    end
`ifdef CHARACTER_EXTRA_LIFE_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      coins_q <= '0;
      oneup_pulse <= 1'b0;
    end else begin
      coins_q <= coins_d;
      oneup_pulse <= oneup_d;
    end
`endif
  char_timer #(.W(TIMER_W)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(t_load),
    .load_val(t_val),
    .zero(t_zero)
  );
endmodule

// File: tb/tb_character_state_ctrl.sv
// tb_character_state_ctrl: scoreboard bench; pulse events are checked by a monitor against queued expectations.
module tb_character_state_ctrl;
  typedef struct {
    logic [1:0] st;
    int score;
    int life;
    logic die, stomp, coin, oneup;
  } exp_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [3:0] collision = '0;
  logic [10:0] collision_type = '0;
  logic collision_valid = 0, restart = 0, v2 = 0;
  logic [1:0] state, state2;
  logic [10:0] score;
  logic [3:0] score2, life, life2;
  logic die_pulse, stomp_pulse, coin_pulse, d2, s2, c2;
`ifdef CHARACTER_EXTRA_LIFE_EN
  logic oneup_pulse, o2;
`endif
  int cmp = 0, bad = 0;
  exp_t sb[$];
  exp_t mon_e;
  character_state_ctrl dut (
    .clk(clk), .rst_n(rst_n), .collision(collision), .collision_type(collision_type),
    .collision_valid(collision_valid), .restart(restart), .state(state), .score(score),
    .life(life), .die_pulse(die_pulse), .stomp_pulse(stomp_pulse),
`ifdef CHARACTER_EXTRA_LIFE_EN
    .oneup_pulse(oneup_pulse),
`endif
    .coin_pulse(coin_pulse)
  );
  character_state_ctrl #(.SCORE_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .collision(collision), .collision_type(collision_type),
    .collision_valid(v2), .restart(restart), .state(state2), .score(score2),
    .life(life2), .die_pulse(d2), .stomp_pulse(s2),
`ifdef CHARACTER_EXTRA_LIFE_EN
    .oneup_pulse(o2),
`endif
    .coin_pulse(c2)
  );
  task automatic chk(string name, int act, int exp);
    cmp++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic void push(logic [1:0] st, int sc, int lf, logic d, logic s, logic c, logic o);
    sb.push_back('{st, sc, lf, d, s, c, o});
  endfunction
  task automatic send(logic [10:0] t, logic [3:0] c);
    collision_type = t;
    collision = c;
    collision_valid = 1;
    @(negedge clk);
    collision_valid = 0;
  endtask
  task automatic wait_leave(logic [1:0] s, output int n);
    n = 0;
    while (state == s && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask
  always @(negedge clk)
    if (rst_n && (die_pulse || stomp_pulse || coin_pulse)) begin
      if (sb.size() == 0) chk("unexpected_pulse", int'({die_pulse, stomp_pulse, coin_pulse}), 0);
      else begin
        mon_e = sb.pop_front();
        chk("ev_state", state, mon_e.st);
        chk("ev_score", score, mon_e.score);
        chk("ev_life", life, mon_e.life);
        chk("ev_die", die_pulse, mon_e.die);
        chk("ev_stomp", stomp_pulse, mon_e.stomp);
        chk("ev_coin", coin_pulse, mon_e.coin);
`ifdef CHARACTER_EXTRA_LIFE_EN
        chk("ev_oneup", oneup_pulse, mon_e.oneup);
`endif
      end
    end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_score", score, 0);
    chk("rst_life", life, 3);
    chk("rst_pulses", int'({die_pulse, stomp_pulse, coin_pulse}), 0);
    rst_n = 1;
    push(0, 1, 3, 0, 0, 1, 0);
    send(102, 4'b0000);
    @(negedge clk);
    chk("coin_one_cycle", coin_pulse, 0);
    push(0, 4, 3, 0, 1, 0, 0);
    send(302, 4'b0100);
    chk("stomp_state", state, 0);
    push(1, 4, 2, 1, 0, 0, 0);
    send(302, 4'b0010);
    wait_leave(1, n);
    chk("dying_cycles", n, 60);
    chk("after_dying", state, 2);
    n = 0;
    collision_type = 302;
    while (state == 2 && n < 1000) begin
      collision_valid = (n == 5 || n == 10);
      collision = (n == 5) ? 4'b0010 : 4'b0100;
      if (n == 10) push(2, 7, 2, 0, 1, 0, 0);
      n++;
      @(negedge clk);
    end
    collision_valid = 0;
    chk("invuln_cycles", n, 120);
    chk("after_invuln", state, 0);
    chk("invuln_life", life, 2);
    chk("invuln_score", score, 7);
    push(1, 7, 1, 1, 0, 0, 0);
    send(302, 4'b0001);
    wait_leave(1, n);
    chk("hit2_invuln", state, 2);
    wait_leave(2, n);
    chk("hit2_alive", state, 0);
    push(1, 7, 0, 1, 0, 0, 0);
    send(302, 4'b1000);
    wait_leave(1, n);
    chk("gameover_state", state, 3);
    chk("gameover_life", life, 0);
    send(102, 4'b0000);
    send(302, 4'b0100);
    send(302, 4'b0010);
    chk("gameover_frozen", score, 7);
    chk("gameover_stays", state, 3);
    restart = 1;
    @(negedge clk);
    restart = 0;
    chk("restart_state", state, 0);
    chk("restart_score", score, 0);
    chk("restart_life", life, 3);
    push(0, 1, 3, 0, 0, 1, 0);
    send(102, 4'b1111);
    restart = 1;
    @(negedge clk);
    restart = 0;
    chk("restart_ignored", score, 1);
    push(1, 1, 2, 1, 0, 0, 0);
    send(302, 4'b0010);
    repeat (10) @(negedge clk);
    chk("mid_dying", state, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("rst_dying_state", state, 0);
    chk("rst_dying_life", life, 3);
    chk("rst_dying_score", score, 0);
    repeat (3) @(negedge clk);
    chk("rst_dying_hold", state, 0);
`ifdef CHARACTER_EXTRA_LIFE_EN
    collision_type = 102;
    collision = 4'b0000;
    collision_valid = 1;
    for (int k = 1; k <= 100; k++) begin
      push(0, k, (k == 100) ? 4 : 3, 0, 0, 1, k == 100);
      @(negedge clk);
    end
    collision_valid = 0;
    chk("oneup_life", life, 4);
`endif
    collision_type = 302;
    collision = 4'b0100;
    v2 = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("sat_score", score2, (3 * k > 15) ? 15 : 3 * k);
    end
    v2 = 0;
    @(negedge clk);
    chk("sat_hold", score2, 15);
    repeat (3) @(negedge clk);
    chk("queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
